// File: rtl/glb_host_dma_if.sv
// rtl/glb_host_dma_if.sv - command, write/read word streams and GLB DRAM-side port bundle
interface glb_host_dma_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [31:0]       wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       rd_data;
    logic [3:0]        dram_w_en;
    logic [ADDR_W-1:0] dram_w_addr;
    logic [31:0]       dram_w_data;
    logic              dram_r_en;
    logic [ADDR_W-1:0] dram_r_addr;
    logic [31:0]       dram_r_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, dram_r_data,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output dram_w_en, dram_w_addr, dram_w_data, dram_r_en, dram_r_addr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, dram_r_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  dram_w_en, dram_w_addr, dram_w_data, dram_r_en, dram_r_addr
    );
endinterface

// File: rtl/glb_host_dma.sv
// rtl/glb_host_dma.sv - host burst engine to the GLB DRAM port; GLB_DMA_ALIGN_CHK_EN adds cmd_err
module glb_host_dma #(
    parameter int ADDR_W        = 32,
    parameter int LEN_W         = 16,
    parameter int RD_FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    glb_host_dma_if.master bus,
    output logic           busy,
    output logic           burst_done
`ifdef GLB_DMA_ALIGN_CHK_EN
    ,
    output logic           cmd_err
`endif
);
    localparam int PW    = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CNT_W = PW + 1;
    localparam int CW    = PW + 2;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              done_q;
    logic              inflight;
    logic [31:0]       fifo_mem [RD_FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CNT_W-1:0]  count;
    logic              cmd_fire, wr_fire, rd_issue, rd_pop, drain_done;
    logic              bad_align, credit_ok, last_word;

`ifdef GLB_DMA_ALIGN_CHK_EN
    logic err_q;
    assign bad_align = (bus.cmd_addr[1:0] != 2'b00);
    assign cmd_err   = err_q;
`else
    assign bad_align = 1'b0;
`endif

    assign last_word = (remaining == LEN_W'(1));
    assign rd_pop    = bus.rd_valid && bus.rd_ready;
    // A pop in the same cycle frees its slot, which keeps reads at one word per cycle.
    assign credit_ok = (CW'(count) + CW'(inflight)) < (CW'(RD_FIFO_DEPTH) + CW'(rd_pop));

    assign bus.rd_valid    = (count != '0);
    assign bus.rd_data     = fifo_mem[rptr];
    assign bus.dram_w_addr = addr;
    assign bus.dram_r_addr = addr;
    assign burst_done      = done_q | drain_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        busy              = 1'b1;
        bus.cmd_ready     = 1'b0;
        bus.wr_ready      = 1'b0;
        bus.dram_w_en     = 4'h0;
        bus.dram_w_data   = 32'h0;
        bus.dram_r_en     = 1'b0;
        cmd_fire          = 1'b0;
        wr_fire           = 1'b0;
        rd_issue          = 1'b0;
        drain_done        = 1'b0;
        case (state)
            IDLE: begin
                busy          = 1'b0;
                bus.cmd_ready = 1'b1;
                cmd_fire      = bus.cmd_valid;
                if (cmd_fire && !bad_align && (bus.cmd_len != '0))
                    state_nxt = bus.cmd_op ? READ : WRITE;
            end
            WRITE: begin
                bus.wr_ready    = 1'b1;
                bus.dram_w_en   = {4{bus.wr_valid}};
                bus.dram_w_data = bus.wr_data;
                wr_fire         = bus.wr_valid;
                if (wr_fire && last_word) state_nxt = IDLE;
            end
            READ: begin
                rd_issue      = (remaining != '0) && credit_ok;
                bus.dram_r_en = rd_issue;
                if (rd_issue && last_word) state_nxt = DRAIN;
            end
            DRAIN: begin
                drain_done = !inflight && (count == '0);
                if (drain_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
            inflight  <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
`ifdef GLB_DMA_ALIGN_CHK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            inflight <= rd_issue;
`ifdef GLB_DMA_ALIGN_CHK_EN
            err_q    <= cmd_fire && bad_align;
`endif
            if (cmd_fire) begin
                addr      <= bus.cmd_addr & ~ADDR_W'(3);
                remaining <= bus.cmd_len;
                if (!bad_align && (bus.cmd_len == '0)) done_q <= 1'b1;
            end else if (wr_fire || rd_issue) begin
                addr      <= addr + ADDR_W'(4);
                remaining <= remaining - LEN_W'(1);
            end
            if (wr_fire && last_word) done_q <= 1'b1;
            if (inflight) wptr <= wptr + PW'(1);
            if (rd_pop)   rptr <= rptr + PW'(1);
            count <= count + CNT_W'(inflight) - CNT_W'(rd_pop);
        end
    end

    // The GLB returns data exactly one cycle after dram_r_en, so the push is just the delayed issue.
    always_ff @(posedge clk) begin
        if (inflight) fifo_mem[wptr] <= bus.dram_r_data;
    end
endmodule
